// File: rtl/cache_pkg.sv
// Shared types for the D-cache array arbiter: ownership states and the bundle
// of tag-array, data-array and memory-port controls that one owner drives.
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      OWN_RD = 2'd1,
      OWN_WR = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic [5:0]   index;
      logic [21:0]  TA_in;
      logic         TA_write;
      logic         TA_read;
      logic [127:0] DA_in;
      logic [15:0]  DA_write;
      logic         DA_read;
      logic         D_req;
      logic         D_write;
      logic [31:0]  D_addr;
      logic [31:0]  D_in;
      logic [2:0]   D_type;
   } array_bus_t;

   // DA_write byte enables are active-low, so "no write" is all ones.
   localparam array_bus_t ARRAY_BUS_IDLE = '{
      index:    6'd0,
      TA_in:    22'd0,
      TA_write: 1'b0,
      TA_read:  1'b0,
      DA_in:    128'd0,
      DA_write: 16'hffff,
      DA_read:  1'b0,
      D_req:    1'b0,
      D_write:  1'b0,
      D_addr:   32'd0,
      D_in:     32'd0,
      D_type:   3'd0
   };

endpackage

// File: rtl/array_bus_mux.sv
// 2:1 steering of the array/memory bundle; sel is one-hot {wr, rd}, and any
// other value yields the idle bundle.
module array_bus_mux
   import cache_pkg::*;
(
   input  array_bus_t rd_bus,
   input  array_bus_t wr_bus,
   input  logic [1:0] sel,
   output array_bus_t bus
);

   always_comb begin
      // NOTE: default first so every path assigns bus and no latch is inferred.
      bus = ARRAY_BUS_IDLE;
      case (sel)
         2'b01:   bus = rd_bus;
         2'b10:   bus = wr_bus;
         default: bus = ARRAY_BUS_IDLE;
      endcase
   end

endmodule

// File: rtl/dcache_array_arbiter.sv
// Grants the shared tag/data arrays and D-side memory port to either the
// D-cache read or write controller for a whole transaction, round-robin on ties.
module dcache_array_arbiter
   import cache_pkg::*;
#(
   parameter bit FIRST_PRIO_WR = 1'b1,
   parameter int MAX_HOLD      = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         rd_req,
   input  logic         wr_req,
   output logic         rd_gnt,
   output logic         wr_gnt,
   input  logic [5:0]   rd_index,
   input  logic [21:0]  rd_TA_in,
   input  logic         rd_TA_write,
   input  logic         rd_TA_read,
   input  logic [127:0] rd_DA_in,
   input  logic [15:0]  rd_DA_write,
   input  logic         rd_DA_read,
   input  logic         rd_D_req,
   input  logic         rd_D_write,
   input  logic [31:0]  rd_D_addr,
   input  logic [31:0]  rd_D_in,
   input  logic [2:0]   rd_D_type,
   input  logic [5:0]   wr_index,
   input  logic [21:0]  wr_TA_in,
   input  logic         wr_TA_write,
   input  logic         wr_TA_read,
   input  logic [127:0] wr_DA_in,
   input  logic [15:0]  wr_DA_write,
   input  logic         wr_DA_read,
   input  logic         wr_D_req,
   input  logic         wr_D_write,
   input  logic [31:0]  wr_D_addr,
   input  logic [31:0]  wr_D_in,
   input  logic [2:0]   wr_D_type,
   output logic [5:0]   index,
   output logic [21:0]  TA_in,
   output logic         TA_write,
   output logic         TA_read,
   output logic [127:0] DA_in,
   output logic [15:0]  DA_write,
   output logic         DA_read,
   output logic         D_req,
   output logic         D_write,
   output logic [31:0]  D_addr,
   output logic [31:0]  D_in,
   output logic [2:0]   D_type,
   input  logic         D_wait,
   output logic         rd_D_wait,
   output logic         wr_D_wait,
   output logic         hold_err
);

   localparam logic [6:0] HOLD_LIMIT = 7'(MAX_HOLD);

   arb_state_e state, state_nxt;
   logic       last_wr;
   logic [6:0] hold_cnt, hold_cnt_nxt;
   logic       other_waiting;
   logic [1:0] sel;
   array_bus_t rd_bus, wr_bus, bus;

   assign rd_bus = '{rd_index, rd_TA_in, rd_TA_write, rd_TA_read, rd_DA_in, rd_DA_write,
                     rd_DA_read, rd_D_req, rd_D_write, rd_D_addr, rd_D_in, rd_D_type};
   assign wr_bus = '{wr_index, wr_TA_in, wr_TA_write, wr_TA_read, wr_DA_in, wr_DA_write,
                     wr_DA_read, wr_D_req, wr_D_write, wr_D_addr, wr_D_in, wr_D_type};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         rd_gnt   <= 1'b0;
         wr_gnt   <= 1'b0;
         last_wr  <= !FIRST_PRIO_WR;
         hold_cnt <= 7'd0;
         hold_err <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register
         // samples the pre-edge values regardless of statement order.
         state    <= state_nxt;
         rd_gnt   <= (state_nxt == OWN_RD);
         wr_gnt   <= (state_nxt == OWN_WR);
         hold_cnt <= hold_cnt_nxt;
         hold_err <= hold_err | (hold_cnt_nxt == HOLD_LIMIT);
         if (state == IDLE && state_nxt != IDLE)
            last_wr <= (state_nxt == OWN_WR);
      end
   end

   assign other_waiting = (state == OWN_RD && wr_req) || (state == OWN_WR && rd_req);

   always_comb begin
      state_nxt    = state;
      hold_cnt_nxt = hold_cnt;
      case (state)
         IDLE: begin
            if (rd_req && wr_req) state_nxt = last_wr ? OWN_RD : OWN_WR;
            else if (rd_req)      state_nxt = OWN_RD;
            else if (wr_req)      state_nxt = OWN_WR;
         end
         OWN_RD:  if (!rd_req) state_nxt = IDLE;
         OWN_WR:  if (!wr_req) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      // The ownership gap always passes through IDLE, which restarts the count.
      if (state == IDLE)
         hold_cnt_nxt = 7'd0;
      else if (other_waiting && hold_cnt != HOLD_LIMIT)
         hold_cnt_nxt = hold_cnt + 7'd1;
   end

   always_comb begin
      sel       = {wr_gnt, rd_gnt};
      rd_D_wait = rd_gnt ? D_wait : 1'b1;
      wr_D_wait = wr_gnt ? D_wait : 1'b1;
   end

   array_bus_mux u_mux (
      .rd_bus (rd_bus),
      .wr_bus (wr_bus),
      .sel    (sel),
      .bus    (bus)
   );

   assign index    = bus.index;
   assign TA_in    = bus.TA_in;
   assign TA_write = bus.TA_write;
   assign TA_read  = bus.TA_read;
   assign DA_in    = bus.DA_in;
   assign DA_write = bus.DA_write;
   assign DA_read  = bus.DA_read;
   assign D_req    = bus.D_req;
   assign D_write  = bus.D_write;
   assign D_addr   = bus.D_addr;
   assign D_in     = bus.D_in;
   assign D_type   = bus.D_type;

endmodule

// File: tb/tb_dcache_array_arbiter.sv
// Self-checking bench for dcache_array_arbiter: directed sequences plus a
// table of grant vectors scored through an expectation queue.
module tb_dcache_array_arbiter;
   import cache_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         rd_req, wr_req, rd_gnt, wr_gnt;
   logic [5:0]   rd_index, wr_index, index;
   logic [21:0]  rd_TA_in, wr_TA_in, TA_in;
   logic         rd_TA_write, wr_TA_write, TA_write;
   logic         rd_TA_read, wr_TA_read, TA_read;
   logic [127:0] rd_DA_in, wr_DA_in, DA_in;
   logic [15:0]  rd_DA_write, wr_DA_write, DA_write;
   logic         rd_DA_read, wr_DA_read, DA_read;
   logic         rd_D_req, wr_D_req, D_req;
   logic         rd_D_write, wr_D_write, D_write;
   logic [31:0]  rd_D_addr, wr_D_addr, D_addr;
   logic [31:0]  rd_D_in, wr_D_in, D_in;
   logic [2:0]   rd_D_type, wr_D_type, D_type;
   logic         D_wait, rd_D_wait, wr_D_wait, hold_err;

   int checks = 0;
   int errors = 0;

   localparam logic [243:0] IDLE_OUT = {6'd0, 22'd0, 1'b0, 1'b0, 128'd0, 16'hffff,
                                        1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0};

   typedef struct {
      logic rd_req;
      logic wr_req;
      logic exp_rd_gnt;
      logic exp_wr_gnt;
   } vec_t;

   typedef struct {
      logic rd_gnt;
      logic wr_gnt;
      int   row;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   dcache_array_arbiter #(.FIRST_PRIO_WR(1'b1), .MAX_HOLD(4)) dut (
      .clk(clk), .rst(rst), .rd_req(rd_req), .wr_req(wr_req),
      .rd_gnt(rd_gnt), .wr_gnt(wr_gnt),
      .rd_index(rd_index), .rd_TA_in(rd_TA_in), .rd_TA_write(rd_TA_write),
      .rd_TA_read(rd_TA_read), .rd_DA_in(rd_DA_in), .rd_DA_write(rd_DA_write),
      .rd_DA_read(rd_DA_read), .rd_D_req(rd_D_req), .rd_D_write(rd_D_write),
      .rd_D_addr(rd_D_addr), .rd_D_in(rd_D_in), .rd_D_type(rd_D_type),
      .wr_index(wr_index), .wr_TA_in(wr_TA_in), .wr_TA_write(wr_TA_write),
      .wr_TA_read(wr_TA_read), .wr_DA_in(wr_DA_in), .wr_DA_write(wr_DA_write),
      .wr_DA_read(wr_DA_read), .wr_D_req(wr_D_req), .wr_D_write(wr_D_write),
      .wr_D_addr(wr_D_addr), .wr_D_in(wr_D_in), .wr_D_type(wr_D_type),
      .index(index), .TA_in(TA_in), .TA_write(TA_write), .TA_read(TA_read),
      .DA_in(DA_in), .DA_write(DA_write), .DA_read(DA_read), .D_req(D_req),
      .D_write(D_write), .D_addr(D_addr), .D_in(D_in), .D_type(D_type),
      .D_wait(D_wait), .rd_D_wait(rd_D_wait), .wr_D_wait(wr_D_wait),
      .hold_err(hold_err)
   );

   // Protocol and mutual-exclusion properties, sampled at every active edge.
   always @(posedge clk) begin
      if (!rst) begin
         assert (!(rd_gnt && wr_gnt)) else $error("both grants high");
         assert (!(rd_gnt && !rd_req && D_wait)) else $error("rd dropped req during D_wait");
         assert (!(wr_gnt && !wr_req && D_wait)) else $error("wr dropped req during D_wait");
      end
   end

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [243:0] out_bus();
      return {index, TA_in, TA_write, TA_read, DA_in, DA_write, DA_read,
              D_req, D_write, D_addr, D_in, D_type};
   endfunction

   function automatic logic [243:0] rd_in_bus();
      return {rd_index, rd_TA_in, rd_TA_write, rd_TA_read, rd_DA_in, rd_DA_write,
              rd_DA_read, rd_D_req, rd_D_write, rd_D_addr, rd_D_in, rd_D_type};
   endfunction

   function automatic logic [243:0] wr_in_bus();
      return {wr_index, wr_TA_in, wr_TA_write, wr_TA_read, wr_DA_in, wr_DA_write,
              wr_DA_read, wr_D_req, wr_D_write, wr_D_addr, wr_D_in, wr_D_type};
   endfunction

   task automatic randomize_rd();
      rd_index    = 6'($urandom);
      rd_TA_in    = 22'($urandom);
      rd_TA_write = 1'($urandom);
      rd_TA_read  = 1'($urandom);
      rd_DA_in    = {$urandom, $urandom, $urandom, $urandom};
      rd_DA_write = 16'($urandom);
      rd_DA_read  = 1'($urandom);
      rd_D_req    = 1'b1;
      rd_D_write  = 1'($urandom);
      rd_D_addr   = $urandom;
      rd_D_in     = $urandom;
      rd_D_type   = 3'($urandom);
   endtask

   task automatic randomize_wr();
      wr_index    = 6'($urandom);
      wr_TA_in    = 22'($urandom);
      wr_TA_write = 1'($urandom);
      wr_TA_read  = 1'($urandom);
      wr_DA_in    = {$urandom, $urandom, $urandom, $urandom};
      wr_DA_write = 16'($urandom);
      wr_DA_read  = 1'($urandom);
      wr_D_req    = 1'b1;
      wr_D_write  = 1'($urandom);
      wr_D_addr   = $urandom;
      wr_D_in     = $urandom;
      wr_D_type   = 3'($urandom);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      rd_req = 1'b0;
      wr_req = 1'b0;
      D_wait = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      vec_t vecs[14];
      exp_t e;

      // Ties resolve to the side that did not own last; after reset that is wr.
      vecs = '{
         '{1'b1, 1'b1, 1'b0, 1'b1},
         '{1'b1, 1'b1, 1'b0, 1'b1},
         '{1'b1, 1'b0, 1'b0, 1'b0},
         '{1'b1, 1'b0, 1'b1, 1'b0},
         '{1'b1, 1'b1, 1'b1, 1'b0},
         '{1'b0, 1'b1, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b0, 1'b1},
         '{1'b1, 1'b0, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b1, 1'b0},
         '{1'b0, 1'b1, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b0, 1'b1},
         '{1'b1, 1'b0, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b1, 1'b0},
         '{1'b0, 1'b0, 1'b0, 1'b0}
      };

      rst = 1'b1;
      rd_req = 1'b0;
      wr_req = 1'b0;
      D_wait = 1'b0;
      randomize_rd();
      randomize_wr();
      repeat (2) @(negedge clk);
      check("reset rd_gnt", rd_gnt, 1'b0);
      check("reset wr_gnt", wr_gnt, 1'b0);
      check("reset outputs idle", out_bus(), IDLE_OUT);
      check("reset hold_err", hold_err, 1'b0);
      check("reset D_wait blocked", {rd_D_wait, wr_D_wait}, 2'b11);
      rst = 1'b0;

      // Lone read request: grant one edge later, rd bundle steered, wr blocked.
      randomize_rd();
      randomize_wr();
      rd_req = 1'b1;
      D_wait = 1'b1;
      #1;
      check("no steering from req", out_bus(), IDLE_OUT);
      check("rd_gnt before edge", rd_gnt, 1'b0);
      @(negedge clk);
      check("rd alone gnt", {rd_gnt, wr_gnt}, 2'b10);
      check("rd bundle steered", out_bus(), rd_in_bus());
      check("rd owner D_wait high", {rd_D_wait, wr_D_wait}, 2'b11);
      D_wait = 1'b0;
      #1;
      check("rd owner D_wait low", {rd_D_wait, wr_D_wait}, 2'b01);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("rd gnt held", {rd_gnt, wr_gnt}, 2'b10);
      end
      rd_req = 1'b0;
      @(negedge clk);
      check("rd release gnt", {rd_gnt, wr_gnt}, 2'b00);
      check("rd release idle outputs", out_bus(), IDLE_OUT);

      // Tie priority, IDLE gap between owners, and round-robin alternation.
      do_reset();
      for (int i = 0; i < 14; i++) begin
         rd_req = vecs[i].rd_req;
         wr_req = vecs[i].wr_req;
         e.rd_gnt = vecs[i].exp_rd_gnt;
         e.wr_gnt = vecs[i].exp_wr_gnt;
         e.row    = i;
         sb_q.push_back(e);
         @(negedge clk);
         if (sb_q.size() == 0) begin
            check("scoreboard underflow", 1'b1, 1'b0);
         end else begin
            e = sb_q.pop_front();
            check($sformatf("vector %0d grants", e.row), {rd_gnt, wr_gnt}, {e.rd_gnt, e.wr_gnt});
         end
      end
      check("scoreboard drained", 32'(sb_q.size()), 32'd0);
      check("short holds keep hold_err low", hold_err, 1'b0);

      // Write owner steering with a randomised, ignored read bundle.
      do_reset();
      randomize_rd();
      randomize_wr();
      wr_DA_write = 16'h0fff;
      wr_DA_in[127:96] = 32'hDEADBEEF;
      wr_req = 1'b1;
      @(negedge clk);
      check("wr owner gnt", {rd_gnt, wr_gnt}, 2'b01);
      check("wr DA_write", DA_write, 16'h0fff);
      check("wr DA_in top word", DA_in[127:96], 32'hDEADBEEF);
      check("wr DA_in", DA_in, wr_DA_in);
      check("wr bundle steered", out_bus(), wr_in_bus());
      randomize_rd();
      #1;
      check("rd bundle ignored", out_bus(), wr_in_bus());
      wr_req = 1'b0;
      @(negedge clk);
      check("wr release idle", out_bus(), IDLE_OUT);

      // Asynchronous reset in the middle of a write transaction stalled on D_wait.
      do_reset();
      randomize_wr();
      wr_DA_write = 16'h0000;
      wr_req = 1'b1;
      D_wait = 1'b1;
      @(negedge clk);
      check("pre-reset wr gnt", wr_gnt, 1'b1);
      check("pre-reset wr_D_wait", wr_D_wait, 1'b1);
      check("pre-reset DA_write", DA_write, 16'h0000);
      #2;
      rst = 1'b1;
      #1;
      check("async reset gnts", {rd_gnt, wr_gnt}, 2'b00);
      check("async reset DA_write", DA_write, 16'hffff);
      check("async reset D_req", D_req, 1'b0);
      check("async reset state", dut.state, IDLE);
      wr_req = 1'b0;
      D_wait = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post-reset gnts", {rd_gnt, wr_gnt}, 2'b00);

      // Hold watchdog with MAX_HOLD=4: wr owns while rd waits.
      do_reset();
      rd_req = 1'b1;
      wr_req = 1'b1;
      @(negedge clk);
      check("hold wr gnt", wr_gnt, 1'b1);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         check($sformatf("hold_err after wait %0d", k), hold_err, (k >= 4) ? 1'b1 : 1'b0);
      end
      wr_req = 1'b0;
      @(negedge clk);
      check("hold idle gap", {rd_gnt, wr_gnt, hold_err}, 3'b001);
      @(negedge clk);
      check("hold rd gets grant", {rd_gnt, wr_gnt, hold_err}, 3'b101);
      rd_req = 1'b0;
      repeat (2) @(negedge clk);
      check("hold_err sticky", hold_err, 1'b1);
      do_reset();
      check("hold_err cleared by reset", hold_err, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
